soft_reset_ctrl: RTL and testbench
==================================

Name: soft_reset_ctrl

Overview:
- Reset-request initiator that drives the active-low external reset input of the system reset generator.
- Turns software reset requests and watchdog expiry into a clean, minimum-width reset pulse.
- Before a software reset, it asks peripherals to quiesce and waits for their acknowledge or a timeout.
- After the pulse it tracks the generator's peripheral_aresetn feedback until release, then reports completion and the cause.

Parameters:
C_RST_PULSE, 16, cycles ext_reset_out is held low (legal 4..255)
C_QUIESCE_TIMEOUT, 256, max cycles waiting for quiesce_ack (legal 1..65535)
C_RELEASE_TIMEOUT, 1024, max cycles waiting for peripheral_aresetn to rise after the pulse (legal 1..65535)
C_WDT_EN, 1, 1 enables watchdog, 0 ties watchdog logic off
C_WDT_TIMEOUT, 65535, cycles without wdt_kick before watchdog reset (legal 2..2^24-1)

Ports:
slowest_sync_clk  input  1  clock; same clock as the reset generator
rstn  input  1  asynchronous active-low reset (power-on only)
sw_rst_req  input  1  single-cycle software reset request
wdt_kick  input  1  single-cycle watchdog restart
quiesce_ack  input  1  level; peripherals are idle
peripheral_aresetn  input  1  feedback from the reset generator, asynchronous assertion
quiesce_req  output  1  level; asks peripherals to drain
ext_reset_out  output  1  active-low reset request to the generator's external reset input
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on return to IDLE after a reset sequence
rst_cause  output  2  00 none, 01 software, 10 watchdog, 11 timeout-forced; held until the next sequence starts
timeout_flag  output  1  sticky; set when any quiesce or release timeout occurs; cleared only by rstn

Behaviour:
- Reset (rstn low):
  - state=IDLE; quiesce_req=0, ext_reset_out=1, busy=0, done=0, rst_cause=00, timeout_flag=0.
  - Counters and the synchronizer are cleared to 0.
- peripheral_aresetn passes through a 2-flop synchronizer (cleared to 0 by rstn) before use. The result is pa_s.
- States: IDLE, QUIESCE, ASSERT, WAIT_LOW, WAIT_REL.
- IDLE:
  - Watchdog has priority over sw_rst_req in the same cycle.
  - On watchdog expiry: rst_cause<=10, go to ASSERT (quiesce skipped).
  - Else on sw_rst_req: rst_cause<=01, quiesce_req<=1, go to QUIESCE.
  - The registered output change is visible the cycle after the request.
- QUIESCE:
  - Counter counts up from 0.
  - quiesce_ack=1 -> go to ASSERT.
  - Counter reaches C_QUIESCE_TIMEOUT-1 without ack -> rst_cause<=11, timeout_flag<=1, go to ASSERT.
  - quiesce_req stays 1 through ASSERT, WAIT_LOW and WAIT_REL; it returns to 0 on entry to IDLE.
- ASSERT:
  - ext_reset_out=0 for exactly C_RST_PULSE cycles.
  - Then ext_reset_out<=1 and go to WAIT_LOW.
- WAIT_LOW:
  - Wait for pa_s=0, confirming the generator saw the request.
  - The release counter runs here. Timeout -> timeout_flag<=1, go to IDLE.
- WAIT_REL:
  - Wait for pa_s=1, then go to IDLE with done=1 for one cycle.
  - The release counter continues from WAIT_LOW, so the combined budget is C_RELEASE_TIMEOUT.
  - Timeout -> timeout_flag<=1, rst_cause<=11, go to IDLE with done=1.
- Requests during a sequence:
  - sw_rst_req and wdt_kick while busy are ignored.
  - The watchdog counter is held at 0 while busy and restarts on return to IDLE.
- Watchdog:
  - 24-bit counter, increments each IDLE cycle, cleared by wdt_kick.
  - Expiry when count==C_WDT_TIMEOUT-1 and no kick that cycle; a kick on the terminal cycle wins.
  - Counter saturates and never wraps.
  - C_WDT_EN=0: counter is constant 0 and never expires.
- All outputs are registered. No combinational path from input to output.
- rstn asserted mid-sequence immediately returns all outputs to their reset values; no pulse continuation.

Test Plan:
1. SW reset with ack:
   - Stimulus: sw_rst_req at cycle 10; quiesce_ack high at cycle 20; model pa_s low 3 cycles after ext_reset_out falls, high 50 cycles later.
   - Required: quiesce_req=1 from cycle 11; ext_reset_out low for exactly 16 cycles starting the cycle after ack is sampled; done pulse once pa_s is high; rst_cause=01; timeout_flag=0.
2. Quiesce timeout:
   - Stimulus: sw_rst_req, quiesce_ack held 0.
   - Required: ASSERT entered after 256 QUIESCE cycles; rst_cause=11; timeout_flag=1.
3. Watchdog expiry:
   - Stimulus: C_WDT_TIMEOUT=100, no kicks.
   - Required: ext_reset_out falls 101 cycles after rstn release with quiesce_req never asserted; rst_cause=10.
   - Stimulus: kick at count 99.
   - Required: no reset.
4. Simultaneous sw_rst_req and watchdog expiry:
   - Required: rst_cause=10; sw request dropped; exactly one pulse.
5. Release timeout:
   - Stimulus: pa_s held 1 (generator never responds), C_RELEASE_TIMEOUT=1024.
   - Required: return to IDLE 1024 cycles after the pulse ends; done=1; timeout_flag=1.
6. Reset mid-pulse:
   - Stimulus: drop rstn in ASSERT.
   - Required: ext_reset_out=1, busy=0, rst_cause=00 asynchronously.
   - Stimulus: new sw_rst_req after release.
   - Required: full sequence from scratch.

Source files
------------

// File: rtl/soft_reset_ctrl.sv
// -----------------------------------------------------------------------------
// soft_reset_ctrl
//
// Purpose:
//   Reset-request initiator for a system reset generator. It turns a software
//   reset request or a watchdog expiry into a clean, fixed-width active-low
//   pulse on the generator's external reset input, then follows the
//   generator's peripheral_aresetn feedback until the system is released.
//   A software reset first asks the peripherals to quiesce. The controller
//   waits for their acknowledge, or for a timeout, before it pulses.
//   A watchdog reset pulses immediately.
//
// Ports:
//   slowest_sync_clk    in   clock, shared with the reset generator
//   rstn                in   asynchronous active-low power-on reset
//   sw_rst_req          in   single-cycle software reset request
//   wdt_kick            in   single-cycle watchdog restart
//   quiesce_ack         in   level, peripherals are idle
//   peripheral_aresetn  in   generator feedback (asynchronous assertion)
//   quiesce_req         out  level, asks peripherals to drain
//   ext_reset_out       out  active-low reset request to the generator
//   busy                out  high whenever the FSM is not in IDLE
//   done                out  one-cycle pulse on return to IDLE after a sequence
//   rst_cause           out  00 none, 01 software, 10 watchdog, 11 timeout-forced
//   timeout_flag        out  sticky quiesce/release timeout indicator
// -----------------------------------------------------------------------------
module soft_reset_ctrl #(
  parameter int unsigned C_RST_PULSE       = 16,    // 4..255
  parameter int unsigned C_QUIESCE_TIMEOUT = 256,   // 1..65535
  parameter int unsigned C_RELEASE_TIMEOUT = 1024,  // 1..65535
  parameter int unsigned C_WDT_EN          = 1,     // 0 disables the watchdog
  parameter int unsigned C_WDT_TIMEOUT     = 65535  // 2..2^24-1
) (
  input  logic       slowest_sync_clk,
  input  logic       rstn,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  input  logic       quiesce_ack,
  input  logic       peripheral_aresetn,
  output logic       quiesce_req,
  output logic       ext_reset_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] rst_cause,
  output logic       timeout_flag
);

  // Terminal counts. Each timed phase counts 0..N-1, so N cycles are spent.
  localparam logic [15:0] PULSE_LAST   = 16'(C_RST_PULSE - 1);
  localparam logic [15:0] QUIESCE_LAST = 16'(C_QUIESCE_TIMEOUT - 1);
  localparam logic [15:0] RELEASE_LAST = 16'(C_RELEASE_TIMEOUT - 1);
  localparam logic [23:0] WDT_LAST     = 24'(C_WDT_TIMEOUT - 1);
  localparam logic [23:0] WDT_MAX      = 24'hFF_FFFF;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_SW      = 2'b01;
  localparam logic [1:0] CAUSE_WDT     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUIESCE  = 3'd1,
    ASSERT   = 3'd2,
    WAIT_LOW = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] seq_cnt_reg, seq_cnt_next;
  logic [23:0] wdt_cnt_reg, wdt_cnt_next;
  logic        quiesce_req_reg, quiesce_req_next;
  logic        ext_reset_reg, ext_reset_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [1:0]  rst_cause_reg, rst_cause_next;
  logic        timeout_reg, timeout_next;

  // Two-flop synchronizer for the generator feedback. Its reset value is 0,
  // so the controller treats the system as "held in reset" until the
  // generator reports otherwise.
  logic [1:0]  pa_sync_reg;
  logic        pa_s;

  always_ff @(posedge slowest_sync_clk or negedge rstn) begin
    if (!rstn) begin
      pa_sync_reg <= 2'b00;
    end else begin
      pa_sync_reg <= {pa_sync_reg[0], peripheral_aresetn};
    end
  end

  assign pa_s = pa_sync_reg[1];

  // A kick on the terminal cycle cancels the expiry.
  logic wdt_expire;
  assign wdt_expire = (C_WDT_EN != 0) && (wdt_cnt_reg == WDT_LAST) && !wdt_kick;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge slowest_sync_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      seq_cnt_reg     <= '0;
      wdt_cnt_reg     <= '0;
      quiesce_req_reg <= 1'b0;
      ext_reset_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      rst_cause_reg   <= CAUSE_NONE;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      seq_cnt_reg     <= seq_cnt_next;
      wdt_cnt_reg     <= wdt_cnt_next;
      quiesce_req_reg <= quiesce_req_next;
      ext_reset_reg   <= ext_reset_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      rst_cause_reg   <= rst_cause_next;
      timeout_reg     <= timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    seq_cnt_next     = seq_cnt_reg;
    quiesce_req_next = quiesce_req_reg;
    ext_reset_next   = ext_reset_reg;
    done_next        = 1'b0;
    rst_cause_next   = rst_cause_reg;
    timeout_next     = timeout_reg;

    unique case (state_reg)
      IDLE: begin
        // The watchdog wins over a software request in the same cycle. The
        // software request is dropped, not queued.
        if (wdt_expire) begin
          rst_cause_next = CAUSE_WDT;
          ext_reset_next = 1'b0;
          seq_cnt_next   = '0;
          state_next     = ASSERT;
        end else if (sw_rst_req) begin
          rst_cause_next   = CAUSE_SW;
          quiesce_req_next = 1'b1;
          seq_cnt_next     = '0;
          state_next       = QUIESCE;
        end
      end

      QUIESCE: begin
        // An acknowledge on the terminal cycle still counts as a clean drain.
        if (quiesce_ack) begin
          ext_reset_next = 1'b0;
          seq_cnt_next   = '0;
          state_next     = ASSERT;
        end else if (seq_cnt_reg == QUIESCE_LAST) begin
          rst_cause_next = CAUSE_TIMEOUT;
          timeout_next   = 1'b1;
          ext_reset_next = 1'b0;
          seq_cnt_next   = '0;
          state_next     = ASSERT;
        end else begin
          seq_cnt_next = seq_cnt_reg + 16'd1;
        end
      end

      ASSERT: begin
        // ext_reset_out went low on entry. It stays low for one cycle per
        // count value 0..C_RST_PULSE-1.
        if (seq_cnt_reg == PULSE_LAST) begin
          ext_reset_next = 1'b1;
          seq_cnt_next   = '0;
          state_next     = WAIT_LOW;
        end else begin
          seq_cnt_next = seq_cnt_reg + 16'd1;
        end
      end

      WAIT_LOW: begin
        // The release counter runs through WAIT_LOW and WAIT_REL without
        // restarting, so both phases share one C_RELEASE_TIMEOUT budget. The
        // budget check comes first so the count can never pass the terminal
        // value on the way into WAIT_REL.
        if (seq_cnt_reg == RELEASE_LAST) begin
          timeout_next     = 1'b1;
          quiesce_req_next = 1'b0;
          done_next        = 1'b1;
          seq_cnt_next     = '0;
          state_next       = IDLE;
        end else begin
          seq_cnt_next = seq_cnt_reg + 16'd1;
          if (!pa_s) begin
            state_next = WAIT_REL;
          end
        end
      end

      WAIT_REL: begin
        if (pa_s) begin
          quiesce_req_next = 1'b0;
          done_next        = 1'b1;
          seq_cnt_next     = '0;
          state_next       = IDLE;
        end else if (seq_cnt_reg == RELEASE_LAST) begin
          timeout_next     = 1'b1;
          rst_cause_next   = CAUSE_TIMEOUT;
          quiesce_req_next = 1'b0;
          done_next        = 1'b1;
          seq_cnt_next     = '0;
          state_next       = IDLE;
        end else begin
          seq_cnt_next = seq_cnt_reg + 16'd1;
        end
      end

      default: begin
        quiesce_req_next = 1'b0;
        ext_reset_next   = 1'b1;
        seq_cnt_next     = '0;
        state_next       = IDLE;
      end
    endcase

    // busy is registered from the next state, so it matches state_reg exactly.
    busy_next = (state_next != IDLE);

    // Watchdog counter. It is forced to 0 on any cycle that leaves, spends
    // time in, or returns from a sequence, so counting restarts from 0 on the
    // first IDLE cycle afterwards. It saturates instead of wrapping, which
    // matters only if the terminal count is never matched.
    if ((C_WDT_EN == 0) || (state_reg != IDLE) || (state_next != IDLE) || wdt_kick) begin
      wdt_cnt_next = '0;
    end else if (wdt_cnt_reg != WDT_MAX) begin
      wdt_cnt_next = wdt_cnt_reg + 24'd1;
    end else begin
      wdt_cnt_next = wdt_cnt_reg;
    end
  end

  assign quiesce_req   = quiesce_req_reg;
  assign ext_reset_out = ext_reset_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign rst_cause     = rst_cause_reg;
  assign timeout_flag  = timeout_reg;

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soft_reset_ctrl
//
// Directed bench for soft_reset_ctrl. It uses C_WDT_TIMEOUT=100 and leaves the
// other parameters at their defaults. Inputs change 1 ns after a rising edge,
// and outputs are sampled at the same point, so each step() shows the result
// of exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_soft_reset_ctrl;

  logic       slowest_sync_clk = 1'b0;
  logic       rstn;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic       quiesce_ack;
  logic       peripheral_aresetn;
  logic       quiesce_req;
  logic       ext_reset_out;
  logic       busy;
  logic       done;
  logic [1:0] rst_cause;
  logic       timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 slowest_sync_clk = ~slowest_sync_clk;

  soft_reset_ctrl #(
    .C_RST_PULSE       (16),
    .C_QUIESCE_TIMEOUT (256),
    .C_RELEASE_TIMEOUT (1024),
    .C_WDT_EN          (1),
    .C_WDT_TIMEOUT     (100)
  ) dut (
    .slowest_sync_clk   (slowest_sync_clk),
    .rstn               (rstn),
    .sw_rst_req         (sw_rst_req),
    .wdt_kick           (wdt_kick),
    .quiesce_ack        (quiesce_ack),
    .peripheral_aresetn (peripheral_aresetn),
    .quiesce_req        (quiesce_req),
    .ext_reset_out      (ext_reset_out),
    .busy               (busy),
    .done               (done),
    .rst_cause          (rst_cause),
    .timeout_flag       (timeout_flag)
  );

  task automatic step();
    @(posedge slowest_sync_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int   n;
    int   low;
    int   done_k;
    logic q_seen;

    rstn               = 1'b0;
    sw_rst_req         = 1'b0;
    wdt_kick           = 1'b0;
    quiesce_ack        = 1'b0;
    peripheral_aresetn = 1'b1;
    step();
    step();

    // ---- Power-on reset values ----
    chk("rst_quiesce_req", quiesce_req, 0);
    chk("rst_ext_reset", ext_reset_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", rst_cause, 0);
    chk("rst_timeout_flag", timeout_flag, 0);

    // ---- Watchdog expiry with no kicks ----
    // The count reaches 99 just before the 100th edge after release. That edge
    // expires the watchdog, so ext_reset_out is low in the 101st cycle.
    rstn   = 1'b1;
    n      = 0;
    q_seen = 1'b0;
    while (ext_reset_out === 1'b1 && n < 300) begin
      step();
      n++;
      if (quiesce_req !== 1'b0) q_seen = 1'b1;
    end
    chk("wdt_fall_edges", n, 100);
    chk("wdt_no_quiesce", q_seen, 0);
    chk("wdt_cause", rst_cause, 2);
    chk("wdt_busy", busy, 1);

    n = 0;
    while (ext_reset_out === 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk("wdt_pulse_width", n, 16);

    // ---- Release timeout: the generator never pulls feedback low ----
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("rel_to_cycles", n, 1024);
    chk("rel_to_done", done, 1);
    chk("rel_to_flag", timeout_flag, 1);
    chk("rel_to_busy", busy, 0);
    chk("rel_to_quiesce_req", quiesce_req, 0);
    step();
    chk("rel_to_done_1cyc", done, 0);

    // ---- Kick on the terminal count (count 99) prevents the reset ----
    // The watchdog count was 0 in the done cycle and is 1 now.
    repeat (98) step();
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    chk("kick99_ext_high", ext_reset_out, 1);
    chk("kick99_not_busy", busy, 0);

    // ---- Software request in the same cycle as watchdog expiry ----
    repeat (99) step();
    chk("pre_sim_ext_high", ext_reset_out, 1);
    chk("pre_sim_not_busy", busy, 0);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("sim_cause_wdt", rst_cause, 2);
    chk("sim_ext_low", ext_reset_out, 0);
    chk("sim_no_quiesce", quiesce_req, 0);
    low    = 0;
    q_seen = 1'b0;
    n      = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (ext_reset_out === 1'b0) low++;
      if (quiesce_req !== 1'b0) q_seen = 1'b1;
      step();
      n++;
    end
    chk("sim_done", done, 1);
    chk("sim_one_pulse_cycles", low, 16);
    chk("sim_quiesce_never", q_seen, 0);
    step();
    chk("sim_sw_dropped", busy, 0);

    // ---- Quiesce timeout, then rstn dropped mid-pulse ----
    rstn = 1'b0;
    step();
    chk("rstn_clears_flag", timeout_flag, 0);
    rstn = 1'b1;
    step();
    step();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("qto_quiesce_req", quiesce_req, 1);
    n = 0;
    while (ext_reset_out === 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("qto_quiesce_cycles", n, 256);
    chk("qto_cause", rst_cause, 3);
    chk("qto_flag", timeout_flag, 1);
    chk("qto_quiesce_held", quiesce_req, 1);

    repeat (3) step();
    chk("mid_ext_low", ext_reset_out, 0);
    // rstn falls between clock edges. The outputs must clear with no edge.
    rstn = 1'b0;
    #2;
    chk("async_ext_high", ext_reset_out, 1);
    chk("async_busy", busy, 0);
    chk("async_cause", rst_cause, 0);
    chk("async_quiesce_req", quiesce_req, 0);
    chk("async_flag", timeout_flag, 0);
    step();
    rstn = 1'b1;  // cycle 0 begins

    // ---- Full software sequence with acknowledge, from scratch ----
    repeat (10) step();  // cycle 10
    chk("sw_pre_quiesce_req", quiesce_req, 0);
    sw_rst_req = 1'b1;
    step();  // cycle 11
    sw_rst_req = 1'b0;
    chk("sw_quiesce_req_c11", quiesce_req, 1);
    chk("sw_busy_c11", busy, 1);
    repeat (9) step();  // cycle 20
    chk("sw_ext_high_c20", ext_reset_out, 1);
    chk("sw_quiesce_req_c20", quiesce_req, 1);
    quiesce_ack = 1'b1;
    step();
    quiesce_ack = 1'b0;
    chk("sw_fall_after_ack", ext_reset_out, 0);

    // k counts cycles since ext_reset_out fell. The generator model pulls its
    // feedback low 3 cycles after the fall and releases it 50 cycles later.
    // Two synchronizer edges plus one FSM edge put done at k=56.
    low    = 0;
    done_k = -1;
    for (int k = 0; k < 200; k++) begin
      if (ext_reset_out === 1'b0) low++;
      if (k == 20) chk("sw_quiesce_req_held", quiesce_req, 1);
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k == 3) peripheral_aresetn = 1'b0;
      if (k == 53) peripheral_aresetn = 1'b1;
      step();
    end
    chk("sw_pulse_width", low, 16);
    chk("sw_done_cycle", done_k, 56);
    chk("sw_cause", rst_cause, 1);
    chk("sw_flag", timeout_flag, 0);
    chk("sw_quiesce_req_end", quiesce_req, 0);
    chk("sw_busy_end", busy, 0);
    step();
    chk("sw_done_1cyc", done, 0);
    chk("sw_cause_held", rst_cause, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
